// File: rtl/prbs_pkg.sv
// Shared types and the PRBS recurrence used by the checker.
// The prediction helper takes vectors widened to 32 bits so any degree up to 32 fits.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // bit j-1 of h/tap holds H[j]/TAP[j]; H[n] always feeds back (x^N implicit)
    function automatic logic prbs_predict(
        input logic [31:0] h,
        input logic [31:0] tap,
        input int          n
    );
        logic p;
        p = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (j == n - 1) begin
                p = p ^ h[j];
            end else if (j < n - 1) begin
                p = p ^ (tap[j] & h[j]);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/prbs_history.sv
// Received-bit history register with next-bit prediction.
// Shifts either the received bit or the prediction into H[1].
module prbs_history
    import prbs_pkg::*;
#(
    parameter int               LENGTH = 8,
    parameter logic [LENGTH:1]  TAP    = 8'hCF
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic load_pred,
    input  logic in_bit,
    output logic pred,
    output logic zero
);

    logic [LENGTH:1] h;

    assign pred = prbs_predict(32'(h), 32'(TAP), LENGTH);
    assign zero = (h == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
        end else if (shift_en) begin
            h <= {h[LENGTH-1:1], load_pred ? pred : in_bit};
        end
    end

endmodule

// File: rtl/prbs_lfsr_checker.sv
// Self-synchronising PRBS checker: search, verify, then free-running compare.
// Reports per-bit errors, a saturating error count and lock status.
module prbs_lfsr_checker
    import prbs_pkg::*;
#(
    parameter int               LENGTH    = 8,
    parameter logic [LENGTH:1]  TAP       = 8'hCF,
    parameter int               LOCK_CNT  = 16,
    parameter int               WINDOW    = 64,
    parameter int               ERR_LIMIT = 8,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_cnt,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             lock_lost
);

    localparam int FW = $clog2(LENGTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    state_t          state;
    logic [FW-1:0]   fill;
    logic [MW-1:0]   match;
    logic [WW-1:0]   win;
    logic [EW-1:0]   werr;
    logic            pred;
    logic            hzero;
    logic            mism;

    assign mism = in_bit ^ pred;

    prbs_history #(
        .LENGTH (LENGTH),
        .TAP    (TAP)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (in_valid),
        .load_pred (state == LOCKED),
        .in_bit    (in_bit),
        .pred      (pred),
        .zero      (hzero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            fill      <= '0;
            match     <= '0;
            win       <= '0;
            werr      <= '0;
            locked    <= 1'b0;
            bit_err   <= 1'b0;
            err_cnt   <= '0;
            lock_lost <= 1'b0;
        end else begin
            bit_err   <= 1'b0;
            lock_lost <= 1'b0;
            if (clr_cnt) begin
                err_cnt <= '0;
            end
            if (in_valid) begin
                unique case (state)
                    SEARCH: begin
                        if (fill == FW'(LENGTH - 1)) begin
                            state <= VERIFY;
                            fill  <= '0;
                            match <= '0;
                        end else begin
                            fill <= fill + FW'(1);
                        end
                    end
                    VERIFY: begin
                        // an all-zero history would "predict" a dead line forever
                        if (hzero || mism) begin
                            match <= '0;
                        end else if (match == MW'(LOCK_CNT - 1)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            match  <= '0;
                            win    <= '0;
                            werr   <= '0;
                        end else begin
                            match <= match + MW'(1);
                        end
                    end
                    LOCKED: begin
                        if (mism) begin
                            bit_err <= 1'b1;
                            if (clr_cnt) begin
                                err_cnt <= CNT_W'(1);
                            end else if (!(&err_cnt)) begin
                                err_cnt <= err_cnt + CNT_W'(1);
                            end
                        end
                        // loss of lock wins over a window wrap in the same bit
                        if (mism && werr == EW'(ERR_LIMIT - 1)) begin
                            state     <= SEARCH;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                            fill      <= '0;
                            win       <= '0;
                            werr      <= '0;
                        end else if (win == WW'(WINDOW - 1)) begin
                            win  <= '0;
                            werr <= '0;
                        end else begin
                            win <= win + WW'(1);
                            if (mism) begin
                                werr <= werr + EW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= SEARCH;
                    end
                endcase
            end
        end
    end

endmodule
